// File: rtl/xhat_centering_pkg.sv
// Shared types and sizing helpers for the xhat centering block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xhat_centering_pkg;

    localparam int DATA_WIDTH_DEF     = 16;
    localparam int BLOCK_SIZE_LOG_DEF = 8;
    localparam int BLOCK_SIZE         = 2 ** BLOCK_SIZE_LOG_DEF;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        WAIT_MEAN = 2'd1,
        DRAIN     = 2'd2
    } state_t;

    // Centered output carries one extra bit so x - mean never overflows.
    function automatic int centered_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/xhat_centering_if.sv
// Stream bundle: xhat samples in, block mean in, centered samples out.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on all three streams.
interface xhat_centering_if
    import xhat_centering_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0]                 xhat_data;
    logic                                  xhat_valid;
    logic                                  xhat_ready;
    logic [DATA_WIDTH-1:0]                 xhatmean_data;
    logic                                  xhatmean_valid;
    logic                                  xhatmean_ready;
    logic [centered_width(DATA_WIDTH)-1:0] xcentered_data;
    logic                                  xcentered_valid;
    logic                                  xcentered_ready;

    // Producer of samples/means and consumer of centered output.
    modport master (
        output xhat_data, xhat_valid, xhatmean_data, xhatmean_valid, xcentered_ready,
        input  xhat_ready, xhatmean_ready, xcentered_data, xcentered_valid
    );

    // The centering block itself.
    modport slave (
        input  xhat_data, xhat_valid, xhatmean_data, xhatmean_valid, xcentered_ready,
        output xhat_ready, xhatmean_ready, xcentered_data, xcentered_valid
    );

endinterface

// File: rtl/xhat_block_ram.sv
// One-block sample buffer: simple dual port, one write, one registered read.
// Latency: read data appears the cycle after rd_en.
// Backpressure: rd_data holds while rd_en is low.
module xhat_block_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2 ** ADDR_WIDTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; output holds when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/xhat_centering.sv
// Buffers one block of xhat samples, then emits each sample minus the block mean.
// Latency: first output valid 2 cycles after entering DRAIN, then 1 sample/cycle.
// Backpressure: output register holds while stalled; inputs blocked outside FILL/mean capture.
module xhat_centering
    import xhat_centering_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int BLOCK_SIZE_LOG = BLOCK_SIZE_LOG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    xhat_centering_if.slave bus
);

    localparam int                      N        = 2 ** BLOCK_SIZE_LOG;
    localparam logic [BLOCK_SIZE_LOG:0] CNT_ONE  = (BLOCK_SIZE_LOG + 1)'(1);
    localparam logic [BLOCK_SIZE_LOG:0] CNT_LAST = (BLOCK_SIZE_LOG + 1)'(N - 1);
    localparam logic [BLOCK_SIZE_LOG-1:0] RD_ONE = BLOCK_SIZE_LOG'(1);

    state_t                    state;
    logic [BLOCK_SIZE_LOG:0]   wr_cnt;     // samples written in FILL, outputs remaining in DRAIN
    logic [BLOCK_SIZE_LOG-1:0] rd_cnt;
    logic [DATA_WIDTH-1:0]     mean_q;
    logic                      mean_held;
    logic                      mem_vld;    // RAM read register holds an unconsumed sample
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [BLOCK_SIZE_LOG:0]   inflight;
    logic                      x_acc;
    logic                      m_acc;
    logic                      out_adv;
    logic                      issue;

    // Ready is only ever high in states that may accept, so no state qualifier is needed.
    assign x_acc    = bus.xhat_valid & bus.xhat_ready;
    assign m_acc    = bus.xhatmean_valid & bus.xhatmean_ready;
    assign out_adv  = ~bus.xcentered_valid | bus.xcentered_ready;
    assign inflight = {{BLOCK_SIZE_LOG{1'b0}}, mem_vld} + {{BLOCK_SIZE_LOG{1'b0}}, bus.xcentered_valid};
    // Issue a read while samples remain unread and the read register will be free next cycle.
    assign issue    = (state == DRAIN) && (wr_cnt > inflight) && (~mem_vld | out_adv);

    xhat_block_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (BLOCK_SIZE_LOG)
    ) u_ram (
        .clk     (clk),
        .wr_en   (x_acc),
        .wr_addr (wr_cnt[BLOCK_SIZE_LOG-1:0]),
        .wr_data (bus.xhat_data),
        .rd_en   (issue),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    // Block FSM with registered readies and the two-stage drain pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= FILL;
            wr_cnt              <= '0;
            rd_cnt              <= '0;
            mean_q              <= '0;
            mean_held           <= 1'b0;
            mem_vld             <= 1'b0;
            bus.xhat_ready      <= 1'b0;
            bus.xhatmean_ready  <= 1'b0;
            bus.xcentered_valid <= 1'b0;
            bus.xcentered_data  <= '0;
        end else begin
            case (state)
                FILL: begin
                    bus.xhat_ready     <= 1'b1;
                    bus.xhatmean_ready <= ~mean_held;
                    if (m_acc) begin
                        mean_q             <= bus.xhatmean_data;
                        mean_held          <= 1'b1;
                        bus.xhatmean_ready <= 1'b0;
                    end
                    if (x_acc) begin
                        wr_cnt <= wr_cnt + CNT_ONE;
                        if (wr_cnt == CNT_LAST) begin
                            bus.xhat_ready <= 1'b0;
                            if (mean_held || m_acc) begin
                                state              <= DRAIN;
                                bus.xhatmean_ready <= 1'b0;
                            end else begin
                                state <= WAIT_MEAN;
                            end
                        end
                    end
                end
                WAIT_MEAN: begin
                    if (m_acc) begin
                        mean_q             <= bus.xhatmean_data;
                        mean_held          <= 1'b1;
                        bus.xhatmean_ready <= 1'b0;
                        state              <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + RD_ONE;
                    end
                    mem_vld <= issue | (mem_vld & ~out_adv);
                    if (out_adv) begin
                        bus.xcentered_valid <= mem_vld;
                        if (mem_vld) begin
                            bus.xcentered_data <= {1'b0, rd_data} - {1'b0, mean_q};
                        end
                    end
                    if (bus.xcentered_valid && bus.xcentered_ready) begin
                        wr_cnt <= wr_cnt - CNT_ONE;
                        if (wr_cnt == CNT_ONE) begin
                            state              <= FILL;
                            rd_cnt             <= '0;
                            mean_held          <= 1'b0;
                            bus.xhat_ready     <= 1'b1;
                            bus.xhatmean_ready <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_xhat_centering.sv
// Directed and randomized-backpressure bench for xhat_centering (N = 4, 16-bit data).
// Latency: checks first output 3 cycles after the block-completing accept.
// Backpressure: drives random output ready and input gaps.
module tb_xhat_centering;

    localparam int N  = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xhat_centering_if #(.DATA_WIDTH(DW)) bus ();

    xhat_centering #(
        .DATA_WIDTH     (DW),
        .BLOCK_SIZE_LOG (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output ready: constant 1 or a coin flip per cycle.
    bit rand_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        bus.xcentered_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Model state: samples and means accepted, literal expectations from directed tests.
    logic [DW-1:0] sq  [$];
    logic [DW-1:0] mq  [$];
    logic [DW:0]   lit [$];
    int            out_in_blk = 0;
    int            out_total  = 0;
    int            done_cyc   = 0;
    bit            done_mark  = 1'b0;
    bit            first_seen = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW:0]   prev_data;

    // Observe every handshake just before the edge that completes it and check against the model.
    always @(negedge clk) begin
        logic [DW:0] exp;
        if (rst) begin
            sq.delete();
            mq.delete();
            out_in_blk = 0;
            done_mark  = 1'b0;
            first_seen = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.xcentered_valid), 32'd1);
                check("stall_data", 32'(bus.xcentered_data), 32'(prev_data));
            end
            if (bus.xhat_valid && bus.xhat_ready) begin
                check("xhat_room", 32'(sq.size() < N && !done_mark), 32'd1);
                sq.push_back(bus.xhat_data);
            end
            if (bus.xhatmean_valid && bus.xhatmean_ready) begin
                check("mean_room", 32'(mq.size()), 32'd0);
                mq.push_back(bus.xhatmean_data);
            end
            if (!done_mark && sq.size() == N && mq.size() == 1) begin
                done_mark = 1'b1;
                done_cyc  = cyc;
            end
            if (bus.xcentered_valid) begin
                check("drain_xhat_ready", 32'(bus.xhat_ready), 32'd0);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    check("first_latency", done_mark ? 32'(cyc - done_cyc) : 32'hFFFF_FFFF, 32'd3);
                end
                if (bus.xcentered_ready) begin
                    check("out_block_complete", 32'(done_mark), 32'd1);
                    if (done_mark) begin
                        exp = {1'b0, sq.pop_front()} - {1'b0, mq[0]};
                        check("out_data", 32'(bus.xcentered_data), 32'(exp));
                        if (lit.size() > 0) begin
                            check("out_literal", 32'(bus.xcentered_data), 32'(lit.pop_front()));
                        end
                        out_in_blk++;
                        if (out_in_blk == N) begin
                            out_in_blk = 0;
                            void'(mq.pop_front());
                            done_mark  = 1'b0;
                            first_seen = 1'b0;
                        end
                    end
                    out_total++;
                end
            end
            prev_stall = bus.xcentered_valid && !bus.xcentered_ready;
            prev_data  = bus.xcentered_data;
        end
    end

    // Offer a sample and/or a mean; each drops once accepted. Returns edges used.
    task automatic send(input bit dx, input logic [DW-1:0] x, input bit dm,
                        input logic [DW-1:0] m, output int n);
        bit px = dx;
        bit pm = dm;
        n = 0;
        bus.xhat_data     = x;
        bus.xhatmean_data = m;
        while ((px || pm) && n < 300) begin
            bus.xhat_valid     = px;
            bus.xhatmean_valid = pm;
            @(negedge clk);
            if (px && bus.xhat_ready)     px = 1'b0;
            if (pm && bus.xhatmean_ready) pm = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        bus.xhat_valid     = 1'b0;
        bus.xhatmean_valid = 1'b0;
        if (px || pm) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: got stuck x=%0b m=%0b expected accept", px, pm);
        end
    endtask

    task automatic wait_outputs(input int tgt);
        int n = 0;
        while (out_total < tgt && n < 600) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("outputs_reached", 32'(out_total), 32'(tgt));
        @(posedge clk);
        #1;
    endtask

    task automatic block(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                         input logic [DW-1:0] x2, input logic [DW-1:0] x3,
                         input logic [DW-1:0] m);
        int n;
        send(1'b1, x0, 1'b0, '0, n);
        send(1'b1, x1, 1'b0, '0, n);
        send(1'b1, x2, 1'b0, '0, n);
        send(1'b1, x3, 1'b0, '0, n);
        send(1'b0, '0, 1'b1, m, n);
    endtask

    initial begin
        int          n;
        int          tgt;
        int          p;
        logic [DW-1:0] xs [4];
        logic [DW-1:0] m;

        bus.xhat_valid     = 1'b0;
        bus.xhatmean_valid = 1'b0;
        bus.xhat_data      = '0;
        bus.xhatmean_data  = '0;

        // Reset state.
        @(negedge clk);
        check("rst_xhat_ready", 32'(bus.xhat_ready), 32'd0);
        check("rst_mean_ready", 32'(bus.xhatmean_ready), 32'd0);
        check("rst_valid", 32'(bus.xcentered_valid), 32'd0);
        check("rst_data", 32'(bus.xcentered_data), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_xhat_ready_c0", 32'(bus.xhat_ready), 32'd0);
        @(negedge clk);
        check("rel_xhat_ready_c1", 32'(bus.xhat_ready), 32'd1);
        check("rel_mean_ready_c1", 32'(bus.xhatmean_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic: mean after the block.
        lit = '{17'h1FFF1, 17'h1FFFB, 17'h00005, 17'h0000F};
        block(16'd10, 16'd20, 16'd30, 16'd40, 16'd25);
        tgt = 4;
        wait_outputs(tgt);

        // Extremes.
        lit = '{17'h10001, 17'h00000, 17'h10001, 17'h00000,
                17'h00000, 17'h0FFFF, 17'h00000, 17'h0FFFF};
        block(16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF);
        tgt += 4;
        wait_outputs(tgt);
        block(16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 16'd0);
        tgt += 4;
        wait_outputs(tgt);

        // Early mean.
        lit = '{17'h00000, 17'h00001, 17'h1FFFF, 17'h00000};
        @(negedge clk);
        check("early_mean_ready", 32'(bus.xhatmean_ready), 32'd1);
        @(posedge clk);
        #1;
        send(1'b0, '0, 1'b1, 16'd100, n);
        check("early_mean_edges", 32'(n), 32'd1);
        xs = '{16'd100, 16'd101, 16'd99, 16'd100};
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("early_mean_ready_low", 32'(bus.xhatmean_ready), 32'd0);
            check("early_no_output", 32'(bus.xcentered_valid), 32'd0);
            @(posedge clk);
            #1;
            send(1'b1, xs[i], 1'b0, '0, n);
        end
        tgt += 4;
        wait_outputs(tgt);

        // Simultaneous last sample and mean.
        lit = '{17'h1FA24, 17'h1FE0C, 17'h001F4, 17'h005DC};
        send(1'b1, 16'd1000, 1'b0, '0, n);
        send(1'b1, 16'd2000, 1'b0, '0, n);
        send(1'b1, 16'd3000, 1'b0, '0, n);
        send(1'b1, 16'd4000, 1'b1, 16'd2500, n);
        check("simul_edges", 32'(n), 32'd1);
        tgt += 4;
        wait_outputs(tgt);

        // Backpressure: 8 back-to-back blocks, random gaps and mean placement.
        rand_rdy = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m = 16'($urandom);
            p = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                xs[i] = 16'($urandom);
                if (i == p && p < 3) send(1'b0, '0, 1'b1, m, n);
                send(1'b1, xs[i], (i == 3 && p == 3), m, n);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            if (p == 4) send(1'b0, '0, 1'b1, m, n);
        end
        tgt += 32;
        wait_outputs(tgt);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-drain after two outputs.
        block(16'd5, 16'd6, 16'd7, 16'd8, 16'd6);
        n = 0;
        while (out_total < tgt + 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pre_reset_outputs", 32'(out_total), 32'(tgt + 2));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("reset_drops_valid", 32'(bus.xcentered_valid), 32'd0);
        check("reset_xhat_ready", 32'(bus.xhat_ready), 32'd0);
        lit.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tgt = out_total;
        lit = '{17'h1FFFF, 17'h00000, 17'h00001, 17'h00002};
        block(16'd1, 16'd2, 16'd3, 16'd4, 16'd2);
        tgt += 4;
        wait_outputs(tgt);
        repeat (5) @(posedge clk);
        #1;
        check("model_samples_empty", 32'(sq.size()), 32'd0);
        check("literals_consumed", 32'(lit.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", checks, errs);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
